// File: rtl/muldiv_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_sequencer_if
// Description : Request/response bundle between the execute stage and the
//               RV32M multiply/divide sequencer.
//               master : pipeline side (drives start/funct3/a/b)
//               slave  : sequencer side (drives busy/done/result/stall)
// Ports       : start, funct3[2:0], a[WIDTH-1:0], b[WIDTH-1:0] (requests)
//               busy, done, result[WIDTH-1:0], stall (responses)
// Revision    : 1.0 - initial release
// ============================================================================
interface muldiv_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       funct3;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             stall;

    modport master (
        output start, funct3, a, b,
        input  busy, done, result, stall
    );

    modport slave (
        input  start, funct3, a, b,
        output busy, done, result, stall
    );
endinterface
`default_nettype wire

// File: rtl/muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_sequencer
// Description : Iterative RV32M multiply/divide unit for the execute stage.
//               Shift-add multiply and restoring divide on operand
//               magnitudes, one bit per cycle over WIDTH cycles, followed by
//               a sign-fix cycle. Divide-by-zero and signed overflow are
//               resolved at accept and complete in one cycle.
// Ports       : clk       - clock, rising edge
//               rst       - synchronous active-high reset
//               bus.start - request, accepted in IDLE or DONE
//               bus.funct3- operation select (RV32M funct3 encoding)
//               bus.a/b   - rs1/rs2 operands, sampled on accept
//               bus.busy  - high in CALC and FIX
//               bus.done  - one-cycle pulse, result valid
//               bus.result- registered result, held until next accept
//               bus.stall - hold the instruction in EX
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic                clk,
    input  logic                rst,
    muldiv_sequencer_if.slave   bus
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_CALC = 2'd1;
    localparam logic [1:0] c_ST_FIX  = 2'd2;
    localparam logic [1:0] c_ST_DONE = 2'd3;

    localparam logic [5:0]         c_CNT_LAST = 6'(WIDTH - 1);
    localparam logic [WIDTH-1:0]   c_ZERO     = '0;
    localparam logic [WIDTH-1:0]   c_ONES     = '1;
    localparam logic [WIDTH-1:0]   c_ONE      = WIDTH'(1);
    localparam logic [WIDTH-1:0]   c_INT_MIN  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [2*WIDTH-1:0] c_ONE_2W   = (2*WIDTH)'(1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]         state_q,  state_d;
    logic [5:0]         cnt_q,    cnt_d;
    logic [2:0]         op_q,     op_d;
    logic               sa_q,     sa_d;
    logic               sb_q,     sb_d;
    // Multiply: {product_hi, multiplier/product_lo}
    // Divide  : {remainder, dividend/quotient}
    logic [2*WIDTH-1:0] acc_q,    acc_d;
    // Multiplicand magnitude (multiply) or divisor magnitude (divide)
    logic [WIDTH-1:0]   opnd_q,   opnd_d;
    logic [WIDTH-1:0]   result_q, result_d;

    // ------------------------------------------------------------------
    // Accept-time decode
    // ------------------------------------------------------------------
    logic               w_accept;
    logic               w_is_div;
    logic               w_sa;
    logic               w_sb;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic               w_div_zero;
    logic               w_div_ovf;
    logic [WIDTH-1:0]   w_special_res;

    always_comb begin
        w_accept = bus.start & ~rst &
                   ((state_q == c_ST_IDLE) | (state_q == c_ST_DONE));
        w_is_div = bus.funct3[2];

        // a is signed for MUL, MULH, MULHSU, DIV, REM
        unique case (bus.funct3)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b110: w_sa = bus.a[WIDTH-1];
            default:                                w_sa = 1'b0;
        endcase
        // b is signed for MUL, MULH, DIV, REM (MULHSU treats b as unsigned)
        unique case (bus.funct3)
            3'b000, 3'b001, 3'b100, 3'b110: w_sb = bus.b[WIDTH-1];
            default:                        w_sb = 1'b0;
        endcase

        w_a_mag = w_sa ? (~bus.a + c_ONE) : bus.a;
        w_b_mag = w_sb ? (~bus.b + c_ONE) : bus.b;

        w_div_zero = w_is_div & (bus.b == c_ZERO);
        // Signed overflow only exists for DIV/REM (funct3[0] clear)
        w_div_ovf  = w_is_div & ~bus.funct3[0] &
                     (bus.a == c_INT_MIN) & (bus.b == c_ONES);

        // funct3[1] distinguishes REM/REMU from DIV/DIVU
        if (w_div_zero) begin
            w_special_res = bus.funct3[1] ? bus.a : c_ONES;
        end else begin
            w_special_res = bus.funct3[1] ? c_ZERO : c_INT_MIN;
        end
    end

    // ------------------------------------------------------------------
    // Iteration datapath
    // ------------------------------------------------------------------
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_next;
    logic [WIDTH:0]     w_rem_sh;
    logic [WIDTH:0]     w_trial;
    logic [2*WIDTH-1:0] w_div_next;

    always_comb begin
        // Multiply: conditional add into the upper half, then shift the
        // whole accumulator (including the carry) right by one.
        w_mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                     (acc_q[0] ? {1'b0, opnd_q} : {1'b0, c_ZERO});
        w_mul_next = {w_mul_sum, acc_q[WIDTH-1:1]};

        // Divide: the remainder always stays below the divisor, so the
        // shifted remainder fits in WIDTH+1 bits and bit WIDTH of the
        // trial difference is a clean borrow flag.
        w_rem_sh = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        w_trial  = w_rem_sh - {1'b0, opnd_q};
        if (!w_trial[WIDTH]) begin
            w_div_next = {w_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end else begin
            w_div_next = {w_rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end
    end

    // ------------------------------------------------------------------
    // Sign fix-up applied in FIX
    // ------------------------------------------------------------------
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH-1:0]   w_fix_res;

    always_comb begin
        w_prod = (sa_q ^ sb_q) ? (~acc_q + c_ONE_2W) : acc_q;
        // Sign flags are zero for the unsigned ops, so no extra op
        // qualification is needed here.
        w_quo  = (sa_q ^ sb_q) ? (~acc_q[WIDTH-1:0] + c_ONE)
                               : acc_q[WIDTH-1:0];
        w_rem  = sa_q ? (~acc_q[2*WIDTH-1:WIDTH] + c_ONE)
                      : acc_q[2*WIDTH-1:WIDTH];

        unique case (op_q)
            3'b000:          w_fix_res = w_prod[WIDTH-1:0];
            3'b001, 3'b010,
            3'b011:          w_fix_res = w_prod[2*WIDTH-1:WIDTH];
            3'b100, 3'b101:  w_fix_res = w_quo;
            default:         w_fix_res = w_rem;
        endcase
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        result_d = result_q;

        if (w_accept) begin
            op_d  = bus.funct3;
            sa_d  = w_sa;
            sb_d  = w_sb;
            cnt_d = 6'd0;
            if (w_is_div) begin
                acc_d  = {c_ZERO, w_a_mag};
                opnd_d = w_b_mag;
            end else begin
                acc_d  = {c_ZERO, w_b_mag};
                opnd_d = w_a_mag;
            end

            if (w_div_zero | w_div_ovf) begin
                state_d  = c_ST_DONE;
                result_d = w_special_res;
            end else begin
                state_d  = c_ST_CALC;
            end
        end else begin
            unique case (state_q)
                c_ST_CALC: begin
                    acc_d = op_q[2] ? w_div_next : w_mul_next;
                    cnt_d = cnt_q + 6'd1;
                    if (cnt_q == c_CNT_LAST) begin
                        state_d = c_ST_FIX;
                    end
                end
                c_ST_FIX: begin
                    result_d = w_fix_res;
                    state_d  = c_ST_DONE;
                end
                c_ST_DONE: begin
                    state_d = c_ST_IDLE;
                end
                default: begin
                    state_d = c_ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= c_ST_IDLE;
            cnt_q    <= 6'd0;
            op_q     <= 3'd0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            acc_q    <= '0;
            opnd_q   <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            result_q <= result_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        bus.busy   = (state_q == c_ST_CALC) | (state_q == c_ST_FIX);
        bus.done   = (state_q == c_ST_DONE);
        bus.result = result_q;
        bus.stall  = ~rst & (w_accept | bus.busy);
    end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_sequencer
// Description : Directed scoreboard bench for muldiv_sequencer. Stimulus
//               pushes the hand-computed result and the cycle at which done
//               must appear; an independent monitor pops on every done.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_sequencer;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    muldiv_sequencer_if #(.WIDTH(32)) bus ();

    muldiv_sequencer #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        int          at;
        string       name;
    } exp_t;

    exp_t sb_q[$];

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest expectation
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst === 1'b0 && bus.done === 1'b1) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got done=1 want no pending op (cycle %0d)", cyc);
            end else begin
                e = sb_q.pop_front();
                check({e.name, "_result"},  bus.result, e.res);
                check({e.name, "_done_at"}, 32'(cyc),   32'(e.at));
            end
        end
    end

    // Drive a request for one cycle; optionally register its expectation
    task automatic issue(string name, logic [2:0] f3, logic [31:0] a,
                         logic [31:0] b, logic [31:0] exp, int lat, bit push);
        bus.start  = 1'b1;
        bus.funct3 = f3;
        bus.a      = a;
        bus.b      = b;
        #1;
        check({name, "_stall_accept"}, 32'(bus.stall), 32'd1);
        if (push) sb_q.push_back('{exp, cyc + lat, name});
        @(posedge clk);
        #1;
        bus.start  = 1'b0;
        // scramble operands while busy; they must have no effect
        bus.a      = $urandom;
        bus.b      = $urandom;
        bus.funct3 = 3'($urandom);
    endtask

    // Returns at the falling edge of the done cycle
    task automatic wait_done(string name, int bound, bit chk_stall);
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                if (chk_stall) check({name, "_stall_done"}, 32'(bus.stall), 32'd0);
                return;
            end
            if (chk_stall) check({name, "_stall_busy"}, 32'(bus.stall), 32'd1);
        end
        total++;
        bad++;
        $display("FAIL %s_timeout: got no done want done within %0d cycles", name, bound);
    endtask

    task automatic run(string name, logic [2:0] f3, logic [31:0] a,
                       logic [31:0] b, logic [31:0] exp, int lat);
        issue(name, f3, a, b, exp, lat, 1'b1);
        wait_done(name, 40, 1'b0);
        @(posedge clk);
        #1;
    endtask

    int done_cnt;

    initial begin
        rst        = 1'b1;
        bus.start  = 1'b1;
        bus.funct3 = 3'b000;
        bus.a      = 32'd5;
        bus.b      = 32'd5;
        repeat (2) @(posedge clk);
        #1;
        check("rst_stall",  32'(bus.stall),  32'd0);
        check("rst_busy",   32'(bus.busy),   32'd0);
        check("rst_done",   32'(bus.done),   32'd0);
        check("rst_result", bus.result,      32'd0);
        rst       = 1'b0;
        bus.start = 1'b0;
        @(posedge clk);
        #1;

        // MUL with full stall profile
        issue("mul_7_m3", 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, 1'b1);
        wait_done("mul_7_m3", 40, 1'b1);
        @(posedge clk);
        #1;

        run("mulh_min",   3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34);
        run("mulhu_max",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
        run("mulhsu_m1",  3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34);
        run("mul_shift",  3'b000, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780, 34);
        run("div_m7_2",   3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 34);
        run("rem_m7_2",   3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 34);
        run("div_7_m2",   3'b100, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 34);
        run("rem_7_m2",   3'b110, 32'd7,         32'hFFFF_FFFE, 32'd1,         34);
        run("divu_100_7", 3'b101, 32'd100,       32'd7,         32'd14,        34);
        run("remu_100_7", 3'b111, 32'd100,       32'd7,         32'd2,         34);
        run("divu_big",   3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         34);
        run("remu_big",   3'b111, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 34);

        // Special cases complete one cycle after accept
        run("div_by0",    3'b100, 32'd5,         32'd0,         32'hFFFF_FFFF, 1);
        run("remu_by0",   3'b111, 32'd5,         32'd0,         32'd5,         1);
        run("divu_by0",   3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF, 1);
        run("rem_by0",    3'b110, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 1);
        run("div_ovf",    3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run("rem_ovf",    3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1);

        // start during CALC is ignored
        issue("ignore", 3'b101, 32'd100, 32'd7, 32'd14, 34, 1'b1);
        repeat (5) @(posedge clk);
        #1;
        bus.start  = 1'b1;
        bus.funct3 = 3'b000;
        bus.a      = 32'd3;
        bus.b      = 32'd3;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check("ignore_busy", 32'(bus.busy), 32'd1);
        wait_done("ignore", 40, 1'b0);
        @(posedge clk);
        #1;

        // Back-to-back: second start in the DONE cycle
        issue("b2b_first", 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, 1'b1);
        wait_done("b2b_first", 40, 1'b0);
        issue("b2b_second", 3'b101, 32'd100, 32'd7, 32'd14, 34, 1'b1);
        repeat (10) @(posedge clk);
        #1;
        check("b2b_hold_result", bus.result,    32'hFFFF_FFEB);
        check("b2b_hold_done",   32'(bus.done), 32'd0);
        wait_done("b2b_second", 40, 1'b0);
        @(posedge clk);
        #1;

        // Reset at CALC cycle 10
        issue("rst_mid", 3'b000, 32'd3, 32'd5, 32'd15, 34, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("rst_mid_stall", 32'(bus.stall), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_mid_busy",   32'(bus.busy), 32'd0);
        check("rst_mid_done",   32'(bus.done), 32'd0);
        check("rst_mid_result", bus.result,    32'd0);
        done_cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done === 1'b1) done_cnt++;
        end
        check("rst_mid_no_done", 32'(done_cnt), 32'd0);
        @(posedge clk);
        #1;

        run("after_rst", 3'b111, 32'd100, 32'd7, 32'd2, 34);

        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
